// File: rtl/riscv_fetch_stage_pkg.sv
// Shared constants for the instruction-fetch stage.
//   INST_NOP         : addi x0,x0,0, shown in IF/ID whenever it holds a bubble
//   fetch_state_t    : fetch controller state encoding
//   DEFAULT_RESET_PC : first fetch address after reset unless overridden
package riscv_fetch_stage_pkg;

    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_BUF  = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/riscv_fetch_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register.
// Keeps the PC, runs a req/ack handshake with instruction memory, presents
// {pc, instruction, valid} to ID, and parks one fetched word while ID stalls.
//
// Ports
//   clk_i, rst_i        : clock (rising edge), async active-high reset
//   IFID_stall_i        : hold IF/ID contents
//   IFID_flush_i        : replace IF/ID contents with a bubble
//   br_taken_i          : EX redirect request
//   br_target_i[31:0]   : redirect address, bits [1:0] ignored
//   imem_req_o          : fetch request
//   imem_addr_o[31:0]   : fetch address (word aligned)
//   imem_ack_i          : memory accepted the request, data valid this cycle
//   imem_rdata_i[31:0]  : instruction word
//   ID_pc_o[31:0]       : PC of the instruction in IF/ID
//   ID_inst_o[31:0]     : instruction in IF/ID (NOP when invalid)
//   ID_valid_o          : IF/ID holds a real instruction
//
// state   | meaning
// IDLE    | one cycle after reset, no request
// REQ     | fetching pc; req/addr held until ack
// BUF     | ID stalled when a fetch completed; word parked in buf_*
// DROP    | wrong-path request still outstanding at drop_addr; pc holds target
module riscv_fetch_stage
    import riscv_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        IFID_stall_i,
    input  logic        IFID_flush_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] ID_pc_o,
    output logic [31:0] ID_inst_o,
    output logic        ID_valid_o
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  drop_addr;
    logic [31:0]  buf_inst;
    logic [31:0]  buf_pc;
    logic [31:0]  id_pc;
    logic [31:0]  id_inst;
    logic         id_valid;

    // Target bits [1:0] are deliberately discarded by word_align.
    logic unused_tgt_lsb;
    assign unused_tgt_lsb = ^br_target_i[1:0];

    // Request side depends only on registers, so memory never sees a
    // combinational path from any input.
    assign imem_req_o  = (state == ST_REQ) || (state == ST_DROP);
    assign imem_addr_o = (state == ST_DROP) ? drop_addr : pc;

    assign ID_pc_o    = id_pc;
    assign ID_inst_o  = id_inst;
    assign ID_valid_o = id_valid;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            drop_addr <= '0;
            buf_inst  <= '0;
            buf_pc    <= '0;
            id_pc     <= '0;
            id_inst   <= INST_NOP;
            id_valid  <= 1'b0;
        end else if (br_taken_i) begin
            pc       <= word_align(br_target_i);
            id_inst  <= INST_NOP;
            id_valid <= 1'b0;
            unique case (state)
                ST_REQ: begin
                    // An unacked request cannot be withdrawn; let it finish
                    // in DROP and throw the data away.
                    if (!imem_ack_i) begin
                        drop_addr <= pc;
                        state     <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (imem_ack_i) state <= ST_REQ;
                end
                default: state <= ST_REQ;
            endcase
        end else begin
            // Consumed by ID (no stall) or flushed: becomes a bubble unless
            // a new instruction is loaded below.
            if (!IFID_stall_i || IFID_flush_i) begin
                id_inst  <= INST_NOP;
                id_valid <= 1'b0;
            end
            unique case (state)
                ST_IDLE: state <= ST_REQ;
                ST_REQ: begin
                    if (imem_ack_i) begin
                        pc <= pc + 32'd4;
                        // A flush blocks the load just like a stall does, so
                        // the fetched word goes to the buffer instead of
                        // being lost.
                        if (IFID_stall_i || IFID_flush_i) begin
                            buf_pc   <= pc;
                            buf_inst <= imem_rdata_i;
                            state    <= ST_BUF;
                        end else begin
                            id_pc    <= pc;
                            id_inst  <= imem_rdata_i;
                            id_valid <= 1'b1;
                        end
                    end
                end
                ST_BUF: begin
                    if (!IFID_stall_i && !IFID_flush_i) begin
                        id_pc    <= buf_pc;
                        id_inst  <= buf_inst;
                        id_valid <= 1'b1;
                        state    <= ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (imem_ack_i) state <= ST_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_fetch_stage.sv
module tb_riscv_fetch_stage;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        IFID_stall_i;
    logic        IFID_flush_i;
    logic        br_taken_i;
    logic [31:0] br_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] ID_pc_o;
    logic [31:0] ID_inst_o;
    logic        ID_valid_o;

    always #5 clk_i = ~clk_i;

    riscv_fetch_stage dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .IFID_stall_i (IFID_stall_i),
        .IFID_flush_i (IFID_flush_i),
        .br_taken_i   (br_taken_i),
        .br_target_i  (br_target_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_rdata_i (imem_rdata_i),
        .ID_pc_o      (ID_pc_o),
        .ID_inst_o    (ID_inst_o),
        .ID_valid_o   (ID_valid_o)
    );

    int n_pass   = 0;
    int n_total  = 0;
    int consumed = 0;

    // Reference model: the in-order program stream ID must consume, restarted
    // at the aligned target on every redirect.
    logic [31:0] exp_q[$];

    int          ack_pct    = 100;
    logic [31:0] delay_addr = '0;
    int          delay_left = 0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic restart_stream(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 2048; i++) exp_q.push_back(start + 32'(i) * 32'd4);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i        = 1'b1;
        IFID_stall_i = 1'b0;
        IFID_flush_i = 1'b0;
        br_taken_i   = 1'b0;
        br_target_i  = '0;
        delay_left   = 0;
        ack_pct      = 100;
        tick();
        tick();
        restart_stream(RESET_PC);
        rst_i = 1'b0;
    endtask

    // Instruction memory: decides ack once the request of this cycle is stable.
    always @(posedge clk_i) begin
        #2;
        if (imem_req_o) begin
            if (delay_left > 0 && imem_addr_o == delay_addr) begin
                delay_left--;
                imem_ack_i = 1'b0;
            end else begin
                imem_ack_i = ($urandom_range(0, 99) < ack_pct);
            end
        end else begin
            imem_ack_i = 1'b0;
        end
        imem_rdata_i = imem_ack_i ? mem_fn(imem_addr_o) : 32'hDEAD_BEEF;
    end

    // Monitor: pops the expected stream whenever ID consumes an instruction,
    // and checks that an unacked request is held stable.
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic        prev_rst = 1'b1;
    logic [31:0] prev_addr = '0;
    logic [31:0] exp_pc;

    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (ID_valid_o && !IFID_stall_i && !br_taken_i) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", ID_pc_o, 32'hFFFF_FFFF);
                end else begin
                    exp_pc = exp_q.pop_front();
                    check("sb_pc", ID_pc_o, exp_pc);
                    check("sb_inst", ID_inst_o, mem_fn(exp_pc));
                    consumed++;
                end
            end
            if (!ID_valid_o) check("sb_bubble_nop", ID_inst_o, NOP);
            if (prev_req && !prev_ack && !prev_rst) begin
                check("hold_req", {31'd0, imem_req_o}, 32'd1);
                check("hold_addr", imem_addr_o, prev_addr);
            end
        end
        prev_req  = imem_req_o;
        prev_ack  = imem_ack_i;
        prev_addr = imem_addr_o;
        prev_rst  = rst_i;
    end

    initial begin
        int waited;
        logic [31:0] tgt;

        rst_i        = 1'b1;
        IFID_stall_i = 1'b0;
        IFID_flush_i = 1'b0;
        br_taken_i   = 1'b0;
        br_target_i  = '0;
        imem_ack_i   = 1'b0;
        imem_rdata_i = '0;
        tick();
        check("rst_req", {31'd0, imem_req_o}, 32'd0);
        check("rst_addr", imem_addr_o, RESET_PC);
        check("rst_id_pc", ID_pc_o, 32'd0);
        check("rst_id_inst", ID_inst_o, NOP);
        check("rst_id_valid", {31'd0, ID_valid_o}, 32'd0);

        // Zero-wait streaming after reset
        do_reset();
        check("idle_no_req", {31'd0, imem_req_o}, 32'd0);
        tick();
        check("first_req", {31'd0, imem_req_o}, 32'd1);
        check("first_addr", imem_addr_o, RESET_PC);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("stream_pc", ID_pc_o, 32'(k) * 32'd4);
            check("stream_valid", {31'd0, ID_valid_o}, 32'd1);
        end

        // Ack delayed 3 cycles on address 8
        do_reset();
        delay_addr = 32'h8;
        delay_left = 3;
        repeat (3) tick();
        for (int c = 0; c < 4; c++) begin
            check("wait_req", {31'd0, imem_req_o}, 32'd1);
            check("wait_addr", imem_addr_o, 32'h8);
            if (c > 0) check("wait_valid", {31'd0, ID_valid_o}, 32'd0);
            tick();
        end
        check("wait_done_pc", ID_pc_o, 32'h8);
        check("wait_done_valid", {31'd0, ID_valid_o}, 32'd1);

        // Stall across the ack of 0x10
        do_reset();
        repeat (5) tick();
        IFID_stall_i = 1'b1;
        repeat (4) begin
            tick();
            check("buf_req", {31'd0, imem_req_o}, 32'd0);
            check("buf_id_pc", ID_pc_o, 32'hC);
            check("buf_id_valid", {31'd0, ID_valid_o}, 32'd1);
        end
        IFID_stall_i = 1'b0;
        tick();
        check("unbuf_pc", ID_pc_o, 32'h10);
        check("unbuf_valid", {31'd0, ID_valid_o}, 32'd1);
        check("unbuf_req", {31'd0, imem_req_o}, 32'd1);
        check("unbuf_addr", imem_addr_o, 32'h14);

        // Redirect while request to 0x20 is outstanding
        do_reset();
        delay_addr = 32'h20;
        delay_left = 5;
        repeat (10) tick();
        check("pend_addr", imem_addr_o, 32'h20);
        br_taken_i  = 1'b1;
        br_target_i = 32'h0000_0102;
        restart_stream(32'h100);
        tick();
        br_taken_i = 1'b0;
        waited = 0;
        while (imem_addr_o == 32'h20 && waited < 20) begin
            check("drop_req", {31'd0, imem_req_o}, 32'd1);
            check("drop_valid", {31'd0, ID_valid_o}, 32'd0);
            tick();
            waited++;
        end
        check("drop_cycles", 32'(waited), 32'd4);
        check("redir_addr", imem_addr_o, 32'h100);
        check("redir_req", {31'd0, imem_req_o}, 32'd1);
        tick();
        check("redir_id_pc", ID_pc_o, 32'h100);
        check("redir_id_inst", ID_inst_o, mem_fn(32'h100));

        // One-cycle flush with zero-wait memory
        do_reset();
        repeat (4) tick();
        check("preflush_pc", ID_pc_o, 32'h8);
        IFID_flush_i = 1'b1;
        tick();
        IFID_flush_i = 1'b0;
        check("flush_inst", ID_inst_o, NOP);
        check("flush_valid", {31'd0, ID_valid_o}, 32'd0);
        check("flush_pc_kept", ID_pc_o, 32'h8);
        check("flush_req", {31'd0, imem_req_o}, 32'd0);
        tick();
        check("postflush_pc", ID_pc_o, 32'hC);
        check("postflush_valid", {31'd0, ID_valid_o}, 32'd1);
        tick();
        check("postflush_next", ID_pc_o, 32'h10);

        // Wrap-around at the top of the address space, then async reset
        do_reset();
        repeat (3) tick();
        br_taken_i  = 1'b1;
        br_target_i = 32'hFFFF_FFFE;
        restart_stream(32'hFFFF_FFFC);
        tick();
        br_taken_i = 1'b0;
        delay_addr = 32'h4;
        delay_left = 50;
        check("wrap_addr0", imem_addr_o, 32'hFFFF_FFFC);
        tick();
        check("wrap_addr1", imem_addr_o, 32'h0);
        check("wrap_id_pc", ID_pc_o, 32'hFFFF_FFFC);
        repeat (2) tick();
        check("stuck_addr", imem_addr_o, 32'h4);
        #2;
        rst_i = 1'b1;
        #1;
        check("arst_req", {31'd0, imem_req_o}, 32'd0);
        check("arst_addr", imem_addr_o, RESET_PC);
        check("arst_valid", {31'd0, ID_valid_o}, 32'd0);

        // Randomized traffic against the stream model
        do_reset();
        ack_pct = 60;
        for (int n = 0; n < 3000; n++) begin
            IFID_stall_i = ($urandom_range(0, 99) < 20);
            IFID_flush_i = !IFID_stall_i && ($urandom_range(0, 99) < 5);
            if ($urandom_range(0, 99) < 3) begin
                tgt         = $urandom;
                br_taken_i  = 1'b1;
                br_target_i = tgt;
                restart_stream({tgt[31:2], 2'b00});
            end else begin
                br_taken_i = 1'b0;
            end
            tick();
        end
        IFID_stall_i = 1'b0;
        IFID_flush_i = 1'b0;
        br_taken_i   = 1'b0;
        ack_pct      = 100;
        repeat (10) tick();
        check("progress", 32'(consumed >= 300), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
